store_buffer: RTL and testbench
===============================

# store_buffer

Posted-store queue between the MEM-stage load/store datapath and the byte-addressed data memory. It accepts stores from the pipeline in one cycle and drains them into data memory one per free cycle. Loads get priority on the single memory address port. A load whose 4-byte window overlaps any pending store is stalled until that store has drained, so the load always reads up-to-date memory contents.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low; 0 clears the queue immediately
- st_valid  in  1  store request this cycle
- st_address  in  32  store byte address
- st_data  in  32  store data, right-aligned; byte k lands at address+k
- st_size  in  3  bytes to write: 1, 2 or 4; 3 is allowed; 0 means no enqueue; 5–7 are enqueued as 4
- st_ready  out  1  queue not full; a store is accepted only when st_valid && st_ready
- ld_valid  in  1  load request this cycle
- ld_address  in  32  load byte address; the load reads bytes address..address+3
- ld_stall  out  1  load overlaps a pending entry; the pipeline must hold the load
- dm_address  out  32  data-memory address port
- dm_data  out  32  data-memory write data
- dm_size  out  3  data-memory write byte count; 0 means read-only cycle
- empty  out  1  no pending entries

## Operation
- **Queue.** Circular FIFO of DEPTH entries {address[31:0], data[31:0], size[2:0]} with head pointer, tail pointer and count[log2(DEPTH):0].
- **Overlap test.** Done on address bits [12:0] with 13-bit wrap-around, matching the data-memory indexing.
  - An entry with byte set {a+i, i<size} overlaps a load with byte set {la+j, j<4} if any two of those bytes are equal mod 8192.
  - ld_stall = ld_valid && (any valid entry overlaps).
- **Port arbitration** is decided each cycle, in priority order:
  - ld_valid && !ld_stall: dm_address=ld_address, dm_size=0, dm_data=0. No drain.
  - Otherwise, if not empty: dm_address/dm_data/dm_size come from the head entry, and the head pops at the next rising edge.
  - Otherwise: dm_address=0, dm_data=0, dm_size=0.
- A stalled load does not take the port, so draining continues and the stall always resolves within at most count cycles.
- **Push.** On st_valid && st_ready && st_size!=0, the entry is written at the tail on the rising edge.
- **Push and pop in the same cycle** are both performed; count is unchanged.
- **st_ready = (count != DEPTH).** A pop in the same cycle does not raise st_ready; there is no full-bypass.
- **st_valid and ld_valid together** is a protocol error from the pipeline, but behaviour is still defined:
  - The load is arbitrated against the old queue contents only.
  - The store is enqueued normally.
- **Store to a non-full queue with an overlapping entry** is allowed. FIFO order preserves write-after-write correctness.

## Timing
- Reset values: count=0, head=0, tail=0, empty=1, st_ready=1, dm_size=0, dm_address=0, dm_data=0, ld_stall=0.
- Reset mid-drain discards all pending entries. The write in flight is not issued because dm_size is forced to 0 while reset is low.
- ld_stall, st_ready, empty and all dm_* outputs are combinational from the registered state and the current inputs. There is no registered output stage.
- Store accepted at edge N:
  - It is visible at the dm_* port during cycle N+1 at the earliest.
  - It is written to data memory at edge N+1 at the earliest.
- A load stalled by a single overlapping head entry (with no competing load) deasserts ld_stall in the cycle after the drain edge.
- Pointers wrap modulo DEPTH.
- Entry addresses are stored as full 32 bits; only the overlap test uses [12:0].

## Structure
- Shared package store_buffer_pkg holds:
  - the entry struct type
  - size constants SB_SIZE_BYTE=1, SB_SIZE_HALF=2, SB_SIZE_WORD=4
  - DM_ADDR_BITS=13
- One natural sub-module, sb_overlap: combinational per-entry comparator taking (entry address, entry size, load address) and producing a hit.
  - It is instantiated DEPTH times; the hits are OR-ed with the entry valid bits.

## Test plan
- **Reset:** hold reset=0 with st_valid=1 → no enqueue, empty=1, st_ready=1, dm_size=0. Release, then push a word store to 0x10 → dm_address=0x10, dm_size=4 the next cycle, then empty=1.
- **Fill/full:** push 4 stores with DEPTH=4 and ld_valid held high at non-overlapping 0x100 → st_ready=0 after the 4th push and the 5th store is not accepted. Drop ld_valid → drains in 4 cycles in FIFO order.
- **Overlap stall:** pending half store at 0x0E (bytes 0x0E–0x0F), load at 0x0C → ld_stall=1 for exactly one cycle while the head drains. Load at 0x10 → ld_stall=0 and the load owns the port.
- **Wrap-around overlap:** pending byte store at 0x1FFF, load at 0x1FFE → ld_stall=1. Pending byte store at 0x0001, load at 0x1FFE → ld_stall=1 (the load's bytes 0x1FFE, 0x1FFF, 0x0000, 0x0001 wrap in 13 bits).
- **Simultaneous push/pop:** with count=2, push one store while the head drains → count stays 2 and the data order is preserved.
- **Reset mid-operation:** 3 pending entries, assert reset for one cycle → empty=1 and dm_size=0 immediately, and no further writes are issued.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-store queue.
package store_buffer_pkg;

    // Data memory is indexed by the low 13 address bits; overlap is tested there.
    localparam int DM_ADDR_BITS = 13;

    localparam logic [2:0] SB_SIZE_BYTE = 3'd1;
    localparam logic [2:0] SB_SIZE_HALF = 3'd2;
    localparam logic [2:0] SB_SIZE_WORD = 3'd4;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic [2:0]  size;
    } sb_entry_t;

    // Sizes above a word are treated as a word write.
    function automatic logic [2:0] sb_clamp_size(input logic [2:0] size);
        return (size > SB_SIZE_WORD) ? SB_SIZE_WORD : size;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side and data-memory-side signals of the store buffer.
interface store_buffer_if;
    logic        st_valid;
    logic [31:0] st_address;
    logic [31:0] st_data;
    logic [2:0]  st_size;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_address;
    logic        ld_stall;
    logic [31:0] dm_address;
    logic [31:0] dm_data;
    logic [2:0]  dm_size;
    logic        empty;

    // Pipeline / environment side.
    modport master (
        output st_valid, st_address, st_data, st_size, ld_valid, ld_address,
        input  st_ready, ld_stall, dm_address, dm_data, dm_size, empty
    );

    // Store buffer side.
    modport slave (
        input  st_valid, st_address, st_data, st_size, ld_valid, ld_address,
        output st_ready, ld_stall, dm_address, dm_data, dm_size, empty
    );
endinterface

// File: rtl/sb_overlap.sv
// Byte-window overlap between one queued store and a 4-byte load,
// evaluated modulo the data-memory size so windows wrap at the top.
module sb_overlap
    import store_buffer_pkg::*;
(
    input  logic [DM_ADDR_BITS-1:0] entry_address,
    input  logic [2:0]              entry_size,
    input  logic [DM_ADDR_BITS-1:0] load_address,
    output logic                    hit
);
    logic [DM_ADDR_BITS-1:0] load_ofs;
    logic [DM_ADDR_BITS-1:0] entry_ofs;

    // Two windows on a ring overlap iff one's start lies inside the other.
    assign load_ofs  = load_address - entry_address;
    assign entry_ofs = entry_address - load_address;

    assign hit = (entry_size != 3'd0) &&
                 ((load_ofs < DM_ADDR_BITS'(entry_size)) ||
                  (entry_ofs < DM_ADDR_BITS'(SB_SIZE_WORD)));
endmodule

// File: rtl/store_buffer.sv
// Posted-store queue: accepts one store per cycle, drains one per free
// memory cycle, gives loads priority and stalls loads that hit a pending store.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  sb
);
    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t        entries_reg [DEPTH];
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W:0]   count_reg, count_next;

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] hit;
    logic             is_empty;
    logic             load_owns;
    logic             push;
    logic             pop;
    sb_entry_t        head_entry;

    // Per-slot occupancy and overlap comparators.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] offset;
            assign offset    = PTR_W'(gi) - head_reg;
            assign valid[gi] = {1'b0, offset} < count_reg;

            sb_overlap u_overlap (
                .entry_address (entries_reg[gi].address[DM_ADDR_BITS-1:0]),
                .entry_size    (entries_reg[gi].size),
                .load_address  (sb.ld_address[DM_ADDR_BITS-1:0]),
                .hit           (hit[gi])
            );
        end
    endgenerate

    assign is_empty    = (count_reg == '0);
    assign head_entry  = entries_reg[head_reg];
    assign sb.empty    = is_empty;
    assign sb.st_ready = (count_reg != (PTR_W + 1)'(DEPTH));
    assign sb.ld_stall = sb.ld_valid && |(valid & hit);
    assign load_owns   = sb.ld_valid && !sb.ld_stall;
    assign pop         = !load_owns && !is_empty;
    assign push        = sb.st_valid && sb.st_ready && (sb.st_size != 3'd0);

    // Memory port arbitration: unstalled load first, then head drain, else idle.
    always_comb begin
        sb.dm_address = '0;
        sb.dm_data    = '0;
        sb.dm_size    = '0;
        if (reset) begin
            if (load_owns) begin
                sb.dm_address = sb.ld_address;
            end else if (!is_empty) begin
                sb.dm_address = head_entry.address;
                sb.dm_data    = head_entry.data;
                sb.dm_size    = head_entry.size;
            end
        end
    end

    // Pointer and occupancy update for push, pop, or both.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (pop) begin
            head_next = head_reg + 1'b1;
        end
        if (push) begin
            tail_next = tail_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Queue control state; reset empties the queue immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry storage; contents are meaningful only under the valid window.
    always_ff @(posedge clk) begin
        if (push && reset) begin
            entries_reg[tail_reg].address <= sb.st_address;
            entries_reg[tail_reg].data    <= sb.st_data;
            entries_reg[tail_reg].size    <= sb_clamp_size(sb.st_size);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: drained writes are compared against
// a scoreboard queue filled when stores are driven.
module tb_store_buffer;
    logic clk;
    logic reset;

    store_buffer_if sbi ();

    store_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] address;
        logic [31:0] data;
        logic [2:0]  size;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] s, input bit accept);
        sbi.st_valid   = 1'b1;
        sbi.st_address = a;
        sbi.st_data    = d;
        sbi.st_size    = s;
        if (accept) begin
            exp_t e;
            e.address = a;
            e.data    = d;
            e.size    = (s > 3'd4) ? 3'd4 : s;
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every write seen on the memory port must be the next expected store.
    always @(negedge clk) begin
        if (reset === 1'b1 && sbi.dm_size != 3'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL drain_unexpected got addr=%h data=%h size=%0d required no write",
                         sbi.dm_address, sbi.dm_data, sbi.dm_size);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (sbi.dm_address !== e.address || sbi.dm_data !== e.data || sbi.dm_size !== e.size)
                    $display("FAIL drain_order got addr=%h data=%h size=%0d required addr=%h data=%h size=%0d",
                             sbi.dm_address, sbi.dm_data, sbi.dm_size, e.address, e.data, e.size);
                else begin
                    passes++;
                    $display("drain addr=%h data=%h size=%0d", sbi.dm_address, sbi.dm_data, sbi.dm_size);
                end
            end
        end
    end

    task automatic test_reset();
        sbi.st_valid = 1'b1; sbi.st_address = 32'h40; sbi.st_data = 32'h0BAD0BAD; sbi.st_size = 3'd4;
        sbi.ld_valid = 1'b1; sbi.ld_address = 32'h44;
        tick(); tick();
        @(negedge clk);
        checks++;
        if (sbi.empty !== 1'b1 || sbi.st_ready !== 1'b1 || sbi.ld_stall !== 1'b0)
            $display("FAIL reset_flags got empty=%b ready=%b stall=%b required 1 1 0",
                     sbi.empty, sbi.st_ready, sbi.ld_stall);
        else passes++;
        checks++;
        if (sbi.dm_size !== 3'd0 || sbi.dm_address !== 32'h0 || sbi.dm_data !== 32'h0)
            $display("FAIL reset_port got addr=%h data=%h size=%0d required 0 0 0",
                     sbi.dm_address, sbi.dm_data, sbi.dm_size);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b1; sbi.st_valid = 1'b0; sbi.ld_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sbi.empty !== 1'b1) $display("FAIL reset_no_enqueue got empty=%b required 1", sbi.empty);
        else passes++;
        tick();
        drive_store(32'h10, 32'hA5A51234, 3'd4, 1'b1);
        tick();
        sbi.st_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sbi.dm_address !== 32'h10 || sbi.dm_size !== 3'd4)
            $display("FAIL first_store_visible got addr=%h size=%0d required 00000010 4",
                     sbi.dm_address, sbi.dm_size);
        else passes++;
        tick();
        @(negedge clk);
        checks++;
        if (sbi.empty !== 1'b1) $display("FAIL first_store_drained got empty=%b required 1", sbi.empty);
        else passes++;
        tick();
    endtask

    task automatic test_fill_full();
        logic [31:0] addrs [4] = '{32'h20, 32'h24, 32'h28, 32'h2C};
        logic [31:0] datas [4] = '{32'h11111111, 32'h00002222, 32'h00333333, 32'h44444444};
        logic [2:0]  sizes [4] = '{3'd4, 3'd2, 3'd3, 3'd7};
        sbi.ld_valid = 1'b1; sbi.ld_address = 32'h100;
        for (int i = 0; i < 4; i++) begin
            drive_store(addrs[i], datas[i], sizes[i], 1'b1);
            @(negedge clk);
            checks++;
            if (sbi.st_ready !== 1'b1) $display("FAIL fill_ready_%0d got %b required 1", i, sbi.st_ready);
            else passes++;
            tick();
        end
        drive_store(32'h30, 32'hDEAD0005, 3'd4, 1'b0);
        @(negedge clk);
        checks++;
        if (sbi.st_ready !== 1'b0) $display("FAIL full_ready got %b required 0", sbi.st_ready);
        else passes++;
        checks++;
        if (sbi.ld_stall !== 1'b0 || sbi.dm_address !== 32'h100 || sbi.dm_size !== 3'd0)
            $display("FAIL full_load_port got stall=%b addr=%h size=%0d required 0 00000100 0",
                     sbi.ld_stall, sbi.dm_address, sbi.dm_size);
        else passes++;
        tick();
        sbi.ld_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sbi.st_ready !== 1'b0 || sbi.dm_size !== 3'd4)
            $display("FAIL full_no_bypass got ready=%b size=%0d required 0 4", sbi.st_ready, sbi.dm_size);
        else passes++;
        tick();
        sbi.st_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (sbi.empty !== 1'b0) $display("FAIL fill_drain_%0d got empty=%b required 0", i, sbi.empty);
            else passes++;
            tick();
        end
        @(negedge clk);
        checks++;
        if (sbi.empty !== 1'b1 || sbi.dm_size !== 3'd0)
            $display("FAIL fill_done got empty=%b size=%0d required 1 0", sbi.empty, sbi.dm_size);
        else passes++;
        tick();
    endtask

    task automatic test_overlap_stall();
        sbi.ld_valid = 1'b0;
        drive_store(32'h0E, 32'h0000BEEF, 3'd2, 1'b1);
        tick();
        sbi.st_valid = 1'b0; sbi.ld_valid = 1'b1; sbi.ld_address = 32'h0C;
        @(negedge clk);
        checks++;
        if (sbi.ld_stall !== 1'b1 || sbi.dm_address !== 32'h0E)
            $display("FAIL overlap_stall got stall=%b addr=%h required 1 0000000e", sbi.ld_stall, sbi.dm_address);
        else passes++;
        tick();
        @(negedge clk);
        checks++;
        if (sbi.ld_stall !== 1'b0 || sbi.dm_address !== 32'h0C || sbi.dm_size !== 3'd0)
            $display("FAIL overlap_release got stall=%b addr=%h size=%0d required 0 0000000c 0",
                     sbi.ld_stall, sbi.dm_address, sbi.dm_size);
        else passes++;
        tick();
        sbi.ld_valid = 1'b0;
        drive_store(32'h0E, 32'h1111CAFE, 3'd2, 1'b1);
        tick();
        sbi.st_valid = 1'b0; sbi.ld_valid = 1'b1; sbi.ld_address = 32'h10;
        @(negedge clk);
        checks++;
        if (sbi.ld_stall !== 1'b0 || sbi.dm_address !== 32'h10 || sbi.dm_size !== 3'd0)
            $display("FAIL adjacent_load got stall=%b addr=%h size=%0d required 0 00000010 0",
                     sbi.ld_stall, sbi.dm_address, sbi.dm_size);
        else passes++;
        tick();
        sbi.ld_valid = 1'b0;
        tick();
        drive_store(32'h50, 32'h12345678, 3'd0, 1'b0);
        tick();
        sbi.st_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sbi.empty !== 1'b1) $display("FAIL size0_no_enqueue got empty=%b required 1", sbi.empty);
        else passes++;
        tick();
    endtask

    task automatic test_wrap_overlap();
        logic [31:0] addrs [6] = '{32'h1FFF, 32'h0001, 32'h0002, 32'h80002001, 32'h1FFB, 32'h1FFC};
        logic [2:0]  sizes [6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3};
        logic        stall [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            sbi.ld_valid = 1'b0;
            drive_store(addrs[i], 32'h00C0FFEE + i, sizes[i], 1'b1);
            tick();
            sbi.st_valid = 1'b0; sbi.ld_valid = 1'b1; sbi.ld_address = 32'h1FFE;
            @(negedge clk);
            checks++;
            if (sbi.ld_stall !== stall[i])
                $display("FAIL wrap_stall_%0d got %b required %b", i, sbi.ld_stall, stall[i]);
            else passes++;
            tick();
            sbi.ld_valid = 1'b0;
            tick();
        end
        @(negedge clk);
        checks++;
        if (sbi.empty !== 1'b1) $display("FAIL wrap_done got empty=%b required 1", sbi.empty);
        else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        sbi.ld_valid = 1'b1; sbi.ld_address = 32'h100;
        drive_store(32'h200, 32'hAAAA0001, 3'd4, 1'b1);
        tick();
        drive_store(32'h204, 32'hAAAA0002, 3'd4, 1'b1);
        tick();
        sbi.ld_valid = 1'b0;
        drive_store(32'h208, 32'hAAAA0003, 3'd4, 1'b1);
        @(negedge clk);
        checks++;
        if (sbi.dm_address !== 32'h200 || sbi.st_ready !== 1'b1)
            $display("FAIL pushpop_head got addr=%h ready=%b required 00000200 1", sbi.dm_address, sbi.st_ready);
        else passes++;
        tick();
        sbi.st_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (sbi.empty !== 1'b0) $display("FAIL pushpop_count_%0d got empty=%b required 0", i, sbi.empty);
            else passes++;
            tick();
        end
        @(negedge clk);
        checks++;
        if (sbi.empty !== 1'b1) $display("FAIL pushpop_done got empty=%b required 1", sbi.empty);
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        sbi.ld_valid = 1'b1; sbi.ld_address = 32'h100;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h300 + 4 * i, 32'h55550000 + i, 3'd4, 1'b1);
            tick();
        end
        sbi.st_valid = 1'b0; sbi.ld_valid = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (sbi.empty !== 1'b1 || sbi.dm_size !== 3'd0)
            $display("FAIL midreset_immediate got empty=%b size=%0d required 1 0", sbi.empty, sbi.dm_size);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (sbi.dm_size !== 3'd0 || sbi.empty !== 1'b1)
                $display("FAIL midreset_quiet_%0d got size=%0d empty=%b required 0 1", i, sbi.dm_size, sbi.empty);
            else passes++;
            tick();
        end
    endtask

    initial begin
        reset          = 1'b0;
        sbi.st_valid   = 1'b0;
        sbi.st_address = '0;
        sbi.st_data    = '0;
        sbi.st_size    = '0;
        sbi.ld_valid   = 1'b0;
        sbi.ld_address = '0;

        test_reset();
        test_fill_full();
        test_overlap_stall();
        test_wrap_overlap();
        test_back_to_back();
        test_reset_mid();

        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
        else passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
